// File: rtl/step_conditioner.sv
// -----------------------------------------------------------------------------
// step_conditioner
//   Input conditioner placed directly in front of the one-hot sequence
//   detector. It synchronises the raw step button and the raw w switch to clk,
//   debounces the button, and emits one single-cycle step strobe for each
//   clean press. w_out is latched on that same strobe, so the detector
//   advances once per press and always sees a stable w.
//
// Parameters
//   SYNC_STAGES      synchroniser depth for btn_raw and w_raw (>= 2)
//   DEBOUNCE_CYCLES  consecutive stable cycles needed to accept a press or a
//                    release (>= 2)
//   REPEAT_CYCLES    auto-repeat period in cycles (>= 2), used only when
//                    STEP_AUTO_REPEAT_EN is defined
//   CNT_W            counter width; 2**CNT_W > max(DEBOUNCE_CYCLES, REPEAT_CYCLES)
//
// Ports
//   clk      in   system clock, rising edge
//   reset    in   synchronous reset, active low
//   btn_raw  in   asynchronous, bouncy step button (1 = pressed)
//   w_raw    in   asynchronous w switch
//   step     out  one-cycle strobe per accepted press (detector clock enable)
//   w_out    out  synchronised w, updated only in the cycle step is high
//   busy     out  high whenever the debounce FSM is not in IDLE
//
// Optional feature
//   STEP_AUTO_REPEAT_EN  when defined, holding the button in PRESSED produces
//                        a further strobe every REPEAT_CYCLES cycles.
// -----------------------------------------------------------------------------
module step_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_CYCLES   = 64,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    input  logic w_raw,
    output logic step,
    output logic w_out,
    output logic busy
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // ---------------------------------------------------------------- sync
    logic [SYNC_STAGES-1:0] btn_sync;
    logic [SYNC_STAGES-1:0] w_sync;
    logic                   btn_s;
    logic                   w_s;

    always_ff @(posedge clk) begin
        if (!reset) begin
            btn_sync <= '0;
            w_sync   <= '0;
        end else begin
            btn_sync <= {btn_sync[SYNC_STAGES-2:0], btn_raw};
            w_sync   <= {w_sync[SYNC_STAGES-2:0], w_raw};
        end
    end

    assign btn_s = btn_sync[SYNC_STAGES-1];
    assign w_s   = w_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------ debounce
    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             step_n;
    logic             w_out_n;

`ifdef STEP_AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_CYCLES - 1);
    logic [CNT_W-1:0] rcnt, rcnt_n;

    always_ff @(posedge clk) begin
        if (!reset) begin
            rcnt <= '0;
        end else begin
            rcnt <= rcnt_n;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            step  <= 1'b0;
            w_out <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            step  <= step_n;
            w_out <= w_out_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        step_n  = 1'b0;
        w_out_n = w_out;
`ifdef STEP_AUTO_REPEAT_EN
        rcnt_n  = rcnt;
`endif
        case (state)
            IDLE: begin
                if (btn_s) begin
                    state_n = PRESS_WAIT;
                    cnt_n   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!btn_s) begin
                    state_n = IDLE;
                end else if (cnt == DB_LAST) begin
                    state_n = PRESSED;
                    step_n  = 1'b1;
                    w_out_n = w_s;
`ifdef STEP_AUTO_REPEAT_EN
                    rcnt_n  = '0;
`endif
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (!btn_s) begin
                    state_n = RELEASE_WAIT;
                    cnt_n   = '0;
                end
`ifdef STEP_AUTO_REPEAT_EN
                else if (rcnt == RP_LAST) begin
                    step_n  = 1'b1;
                    w_out_n = w_s;
                    rcnt_n  = '0;
                end else begin
                    rcnt_n = rcnt + CNT_W'(1);
                end
`endif
            end
            RELEASE_WAIT: begin
                // A release bounce returns to PRESSED without a new strobe.
                if (btn_s) begin
                    state_n = PRESSED;
`ifdef STEP_AUTO_REPEAT_EN
                    rcnt_n  = '0;
`endif
                end else if (cnt == DB_LAST) begin
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule
